// File: rtl/array_drain.sv
// Output-side drain controller for the output-stationary systolic array.
// It sequences the per-column shift-out and clear chains and captures the
// column-skewed result words. The words are reassembled into whole rows and
// handed downstream over valid/ready, top row first. Emission overlaps the
// tail of the drain, so row k is presented as soon as its last column lands.
module array_drain #(
  parameter int HEIGHT = 4,
  parameter int WIDTH  = 4,
  parameter int OWIDTH = 32,
  parameter int LAT    = 1,
  localparam int IW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic [WIDTH-1:0]         en_o,
  output logic [WIDTH-1:0]         clr_o,
  input  logic signed [OWIDTH-1:0] ofm [WIDTH],
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic signed [OWIDTH-1:0] row_data [WIDTH],
  output logic [IW-1:0]            row_idx,
  output logic                     done
);

  localparam int PW = $clog2(HEIGHT + 1);
  localparam int CW = $clog2(WIDTH + HEIGHT + LAT + 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;

  // Cycle offset (from the accepted start) of the last capture in column WIDTH-1.
  localparam logic [CW-1:0] DRAIN_END = CW'(WIDTH + HEIGHT + LAT - 1);
  localparam logic [IW-1:0] LAST_ROW  = IW'(HEIGHT - 1);

  logic [1:0]               state_r;
  logic [CW-1:0]            cnt_r;        // current cycle offset from t0 while draining
  logic signed [OWIDTH-1:0] buf_r [HEIGHT][WIDTH];
  logic [PW-1:0]            rows_cap_r;   // rows whose last column has been captured
  logic [PW-1:0]            next_row_r;   // next row to load into the output register

  logic                     accept_s;
  logic [CW-1:0]            cnt_nxt_s;
  logic [WIDTH-1:0]         en_nxt_s;
  logic [WIDTH-1:0]         clr_nxt_s;
  logic [WIDTH-1:0]         cap_s;
  logic [IW-1:0]            cap_row_s [WIDTH];
  logic                     drain_end_s;
  logic                     hs_s;
  logic                     final_hs_s;
  logic                     bypass_s;
  logic                     eligible_s;
  logic                     load_s;

  // Schedule decode: enable/clear windows for the next cycle, capture slots for this one.
  always_comb begin
    accept_s = (state_r == IDLE) && start;
    if (state_r == IDLE) begin
      cnt_nxt_s = CW'(1);
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
    en_nxt_s  = '0;
    clr_nxt_s = '0;
    cap_s     = '0;
    for (int w = 0; w < WIDTH; w++) begin
      en_nxt_s[w]  = (cnt_nxt_s >= CW'(1 + w)) && (cnt_nxt_s <= CW'(w + HEIGHT));
      clr_nxt_s[w] = (cnt_nxt_s == CW'(w + HEIGHT + 1));
      cap_s[w]     = (state_r == DRAIN) &&
                     (cnt_r >= CW'(1 + w + LAT)) && (cnt_r <= CW'(w + LAT + HEIGHT));
      cap_row_s[w] = IW'(cnt_r - CW'(1 + w + LAT));
    end
    drain_end_s = (state_r == DRAIN) && (cnt_r == DRAIN_END);
    hs_s        = row_valid && row_ready;
    final_hs_s  = hs_s && (row_idx == LAST_ROW);
    // The row completing this very cycle is taken straight from the last column.
    bypass_s    = cap_s[WIDTH-1] && (next_row_r == rows_cap_r);
    eligible_s  = (next_row_r < rows_cap_r) || bypass_s;
    load_s      = (state_r != IDLE) && (!row_valid || hs_s) && !final_hs_s && eligible_s;
  end

  // The last handshake closes the tile; done is coincident with it.
  assign done = final_hs_s;

  // Control FSM: drives the shift/clear chains and the busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      busy    <= 1'b0;
      en_o    <= '0;
      clr_o   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= DRAIN;
            cnt_r   <= cnt_nxt_s;
            busy    <= 1'b1;
            en_o    <= en_nxt_s;
            clr_o   <= clr_nxt_s;
          end
        end
        DRAIN: begin
          cnt_r <= cnt_nxt_s;
          if (drain_end_s) begin
            state_r <= EMIT;
            en_o    <= '0;
            clr_o   <= '0;
          end else begin
            en_o  <= en_nxt_s;
            clr_o <= clr_nxt_s;
          end
        end
        EMIT: begin
          if (final_hs_s) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy    <= 1'b0;
          en_o    <= '0;
          clr_o   <= '0;
        end
      endcase
    end
  end

  // Capture buffer: each column writes its skewed words into row slots in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < HEIGHT; h++) begin
        for (int w = 0; w < WIDTH; w++) begin
          buf_r[h][w] <= '0;
        end
      end
      rows_cap_r <= '0;
    end else begin
      for (int w = 0; w < WIDTH; w++) begin
        if (cap_s[w]) begin
          buf_r[cap_row_s[w]][w] <= ofm[w];
        end
      end
      if (accept_s) begin
        rows_cap_r <= '0;
      end else if (cap_s[WIDTH-1]) begin
        rows_cap_r <= rows_cap_r + PW'(1);
      end
    end
  end

  // Output row register: holds a row stable until it is accepted, then loads the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_valid  <= 1'b0;
      row_idx    <= '0;
      next_row_r <= '0;
      for (int w = 0; w < WIDTH; w++) begin
        row_data[w] <= '0;
      end
    end else begin
      if (accept_s) begin
        row_valid  <= 1'b0;
        next_row_r <= '0;
      end else if (load_s) begin
        row_valid  <= 1'b1;
        row_idx    <= next_row_r[IW-1:0];
        next_row_r <= next_row_r + PW'(1);
        for (int w = 0; w < WIDTH; w++) begin
          row_data[w] <= buf_r[next_row_r[IW-1:0]][w];
        end
        if (bypass_s) begin
          row_data[WIDTH-1] <= ofm[WIDTH-1];
        end
      end else if (hs_s) begin
        row_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_array_drain.sv
// Bench for array_drain: a behavioural 4x4 array model feeds the columns and
// a queue of expected rows is checked as the DUT hands rows downstream.
module tb_array_drain;
  localparam int H = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic row_ready = 1'b0;
  logic load_req = 1'b0;
  logic busy, row_valid, done;
  logic [W-1:0] en_o, clr_o;
  logic signed [31:0] ofm [W];
  logic signed [31:0] row_data [W];
  logic [1:0] row_idx;

  logic signed [31:0] vals [H][W];
  logic signed [31:0] col [W][H];

  typedef struct packed {
    logic [1:0]       idx;
    logic [W*32-1:0]  data;
  } row_t;

  row_t exp_q[$];
  row_t exp_r, got_r, prev_row;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  array_drain #(.HEIGHT(H), .WIDTH(W), .OWIDTH(32), .LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .en_o(en_o), .clr_o(clr_o),
    .ofm(ofm), .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_idx(row_idx), .done(done)
  );

  // Array model: each column shifts its top value out on en_o (one cycle latency).
  always @(posedge clk) begin
    for (int w = 0; w < W; w++) begin
      if (load_req) begin
        for (int h = 0; h < H; h++) col[w][h] <= vals[h][w];
      end else if (en_o[w]) begin
        ofm[w] <= col[w][0];
        for (int h = 0; h < H - 1; h++) col[w][h] <= col[w][h+1];
        col[w][H-1] <= '0;
      end else if (clr_o[w]) begin
        for (int h = 0; h < H; h++) col[w][h] <= '0;
      end
    end
  end

  function automatic row_t cur_row();
    row_t r;
    r.idx  = row_idx;
    r.data = {row_data[3], row_data[2], row_data[1], row_data[0]};
    return r;
  endfunction

  // Fill the model's column contents and queue the rows they should produce.
  task automatic set_vals(input int mode);
    row_t e;
    for (int h = 0; h < H; h++) begin
      for (int w = 0; w < W; w++) begin
        case (mode)
          0: vals[h][w] = 100 * w + h;
          1: vals[h][w] = $urandom;
          2: begin
            case (w)
              0: vals[h][w] = -32'sd1;
              1: vals[h][w] = 32'sh8000_0000;
              2: vals[h][w] = -(h + 1) * 1000;
              default: vals[h][w] = 32'sh7FFF_FFFF - h;
            endcase
          end
          default: vals[h][w] = '0;
        endcase
      end
    end
    for (int h = 0; h < H; h++) begin
      e.idx  = 2'(h);
      e.data = {vals[h][3], vals[h][2], vals[h][1], vals[h][0]};
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (en_o !== 4'b0000) begin bad++; $display("FAIL reset_en got=%b exp=0000", en_o); end
    total++; if (clr_o !== 4'b0000) begin bad++; $display("FAIL reset_clr got=%b exp=0000", clr_o); end
    total++; if (row_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", row_valid); end
    total++; if (cur_row() !== '0) begin bad++; $display("FAIL reset_row got=%h exp=0", cur_row()); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_en, exp_clr;
    set_vals(0);
    pulse_load();
    for (int c = 0; c < 30; c++) begin
      start = (c == 10);
      row_ready = 1'b1;
      #2;
      for (int w = 0; w < W; w++) begin
        exp_en[w]  = (c >= 11 + w) && (c <= 14 + w);
        exp_clr[w] = (c == 15 + w);
      end
      total++; if (en_o !== exp_en) begin bad++; $display("FAIL basic_en c=%0d got=%b exp=%b", c, en_o, exp_en); end
      total++; if (clr_o !== exp_clr) begin bad++; $display("FAIL basic_clr c=%0d got=%b exp=%b", c, clr_o, exp_clr); end
      total++; if (done !== (c == 19)) begin bad++; $display("FAIL basic_done c=%0d got=%b", c, done); end
      total++; if (busy !== (c >= 11 && c <= 19)) begin bad++; $display("FAIL basic_busy c=%0d got=%b", c, busy); end
      total++; if (row_valid !== (c >= 16 && c <= 19)) begin bad++; $display("FAIL basic_valid c=%0d got=%b", c, row_valid); end
      if (row_valid && row_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL basic_extra got idx=%0d exp=none", row_idx); end
        else begin
          exp_r = exp_q.pop_front(); got_r = cur_row();
          if (got_r !== exp_r) begin bad++; $display("FAIL basic_row got=%h exp=%h", got_r, exp_r); end
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL basic_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic rv0;
    set_vals(0);
    pulse_load();
    for (int c = 0; c < 40; c++) begin
      start = (c == 10);
      row_ready = (c >= 30);
      #2;
      if (c == 20) begin
        rv0 = row_valid;
        row_ready = 1'b1; #1;
        total++; if (row_valid !== rv0) begin bad++; $display("FAIL bp_comb_valid got=%b exp=%b", row_valid, rv0); end
        row_ready = 1'b0; #1;
      end
      total++; if (row_valid !== (c >= 16 && c <= 33)) begin bad++; $display("FAIL bp_valid c=%0d got=%b", c, row_valid); end
      total++; if (done !== (c == 33)) begin bad++; $display("FAIL bp_done c=%0d got=%b", c, done); end
      if (c >= 16 && c < 30) begin
        total++; if (cur_row() !== exp_q[0]) begin bad++; $display("FAIL bp_hold c=%0d got=%h exp=%h", c, cur_row(), exp_q[0]); end
      end
      if (row_valid && row_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL bp_extra got idx=%0d exp=none", row_idx); end
        else begin
          exp_r = exp_q.pop_front(); got_r = cur_row();
          if (got_r !== exp_r) begin bad++; $display("FAIL bp_row got=%h exp=%h", got_r, exp_r); end
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_random_ready();
    int ndone = 0;
    logic prev_valid = 1'b0;
    logic prev_hs = 1'b0;
    set_vals(1);
    pulse_load();
    for (int c = 0; c < 300; c++) begin
      start = (c == 2);
      row_ready = 1'($urandom_range(0, 1));
      #2;
      if (prev_valid && !prev_hs) begin
        total++;
        if (row_valid !== 1'b1 || cur_row() !== prev_row) begin
          bad++; $display("FAIL rand_hold c=%0d got=%b/%h exp=1/%h", c, row_valid, cur_row(), prev_row);
        end
      end
      if (row_valid && row_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rand_extra got idx=%0d exp=none", row_idx); end
        else begin
          exp_r = exp_q.pop_front(); got_r = cur_row();
          if (got_r !== exp_r) begin bad++; $display("FAIL rand_row got=%h exp=%h", got_r, exp_r); end
        end
      end
      if (done) ndone++;
      prev_valid = row_valid;
      prev_hs = row_valid && row_ready;
      prev_row = cur_row();
      @(posedge clk); #1;
      if (ndone != 0) break;
    end
    start = 1'b0;
    row_ready = 1'b1;
    total++; if (ndone != 1) begin bad++; $display("FAIL rand_done got=%0d exp=1", ndone); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_left got=%0d exp=0", exp_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_busy();
    logic [W-1:0] exp_en;
    int ndone = 0;
    set_vals(0);
    pulse_load();
    for (int c = 0; c < 30; c++) begin
      start = (c == 10 || c == 12);
      row_ready = 1'b1;
      #2;
      for (int w = 0; w < W; w++) exp_en[w] = (c >= 11 + w) && (c <= 14 + w);
      total++; if (en_o !== exp_en) begin bad++; $display("FAIL busy_en c=%0d got=%b exp=%b", c, en_o, exp_en); end
      if (done) ndone++;
      if (row_valid && row_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL busy_extra got idx=%0d exp=none", row_idx); end
        else begin
          exp_r = exp_q.pop_front(); got_r = cur_row();
          if (got_r !== exp_r) begin bad++; $display("FAIL busy_row got=%h exp=%h", got_r, exp_r); end
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++; if (ndone != 1) begin bad++; $display("FAIL busy_done_count got=%0d exp=1", ndone); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL busy_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_en;
    set_vals(0);
    set_vals(0);
    pulse_load();
    for (int c = 0; c < 36; c++) begin
      start = (c == 10 || c == 19 || c == 20);
      load_req = (c == 20);
      row_ready = 1'b1;
      #2;
      for (int w = 0; w < W; w++)
        exp_en[w] = ((c >= 11 + w) && (c <= 14 + w)) || ((c >= 21 + w) && (c <= 24 + w));
      total++; if (en_o !== exp_en) begin bad++; $display("FAIL b2b_en c=%0d got=%b exp=%b", c, en_o, exp_en); end
      total++; if (done !== (c == 19 || c == 29)) begin bad++; $display("FAIL b2b_done c=%0d got=%b", c, done); end
      total++; if (busy !== ((c >= 11 && c <= 19) || (c >= 21 && c <= 29))) begin bad++; $display("FAIL b2b_busy c=%0d got=%b", c, busy); end
      if (row_valid && row_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_extra got idx=%0d exp=none", row_idx); end
        else begin
          exp_r = exp_q.pop_front(); got_r = cur_row();
          if (got_r !== exp_r) begin bad++; $display("FAIL b2b_row got=%h exp=%h", got_r, exp_r); end
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    load_req = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp_en;
    set_vals(0);
    pulse_load();
    for (int c = 0; c < 36; c++) begin
      start = (c == 10 || c == 22);
      rst = (c >= 16 && c < 18);
      load_req = (c == 21);
      row_ready = 1'b1;
      #2;
      if (c == 15) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre got=%b exp=1", busy); end
      end
      if (c == 16) begin
        total++; if (en_o !== 4'b0000) begin bad++; $display("FAIL mid_en got=%b exp=0000", en_o); end
        total++; if (clr_o !== 4'b0000) begin bad++; $display("FAIL mid_clr got=%b exp=0000", clr_o); end
        total++; if (row_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", row_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
        total++; if (cur_row() !== '0) begin bad++; $display("FAIL mid_row got=%h exp=0", cur_row()); end
      end
      if (c == 18) begin
        exp_q.delete();
        set_vals(0);
      end
      if (c >= 19) begin
        for (int w = 0; w < W; w++) exp_en[w] = (c >= 23 + w) && (c <= 26 + w);
        total++; if (en_o !== exp_en) begin bad++; $display("FAIL mid_en2 c=%0d got=%b exp=%b", c, en_o, exp_en); end
        total++; if (done !== (c == 31)) begin bad++; $display("FAIL mid_done c=%0d got=%b", c, done); end
      end
      if (row_valid && row_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL mid_extra got idx=%0d exp=none", row_idx); end
        else begin
          exp_r = exp_q.pop_front(); got_r = cur_row();
          if (got_r !== exp_r) begin bad++; $display("FAIL mid_row2 got=%h exp=%h", got_r, exp_r); end
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst = 1'b0;
    load_req = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mid_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_negative();
    set_vals(2);
    pulse_load();
    for (int c = 0; c < 24; c++) begin
      start = (c == 5);
      row_ready = 1'b1;
      #2;
      if (row_valid) begin
        total++; if (row_data[0] !== -32'sd1) begin bad++; $display("FAIL neg_m1 got=%0d exp=-1", row_data[0]); end
        total++; if (row_data[1] !== 32'sh8000_0000 || !(row_data[1] < 0)) begin bad++; $display("FAIL neg_min got=%0d exp=-2147483648", row_data[1]); end
      end
      if (row_valid && row_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL neg_extra got idx=%0d exp=none", row_idx); end
        else begin
          exp_r = exp_q.pop_front(); got_r = cur_row();
          if (got_r !== exp_r) begin bad++; $display("FAIL neg_row got=%h exp=%h", got_r, exp_r); end
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL neg_left got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random_ready();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_negative();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
